// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT with a period-synchronised PWM generator.
// Optional feature macro: MPPT_ADAPTIVE_STEP_EN (step doubles on sustained same-direction moves).
module mppt_po_controller #(
    parameter int DATA_W    = 8,
    parameter int DUTY_W    = 8,
    parameter int STEP      = 4,
    parameter int DUTY_MIN  = 16,
    parameter int DUTY_MAX  = 240,
    parameter int DUTY_INIT = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     v_sample,
    input  logic [DATA_W-1:0]     i_sample,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic [DUTY_W-1:0]     duty,
    output logic [2*DATA_W-1:0]   power,
    output logic                  dir_up,
    output logic                  pwm_out,
    output logic                  period_start
);
    localparam int PW = 2 * DATA_W;
    // Extra headroom so duty +/- step never wraps before the clamp compare.
    localparam int XW = DUTY_W + 8;
    localparam logic [XW-1:0] MIN_X  = XW'(DUTY_MIN);
    localparam logic [XW-1:0] MAX_X  = XW'(DUTY_MAX);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);

    typedef enum logic [1:0] {IDLE, MULT, DECIDE} state_t;

    state_t              state, state_nxt;
    logic                run_q;
    logic [DATA_W-1:0]   v_q, i_q;
    logic [PW-1:0]       p_q, prev_power, power_q;
    logic                first_q;
    logic [DUTY_W-1:0]   duty_q;
    logic                dir_q;
    logic                handshake;

    // run_q keeps the block from accepting samples while reset is asserted.
    assign sample_ready = (state == IDLE) && enable && run_q;
    assign handshake    = sample_valid && sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = MULT;
            MULT:    state_nxt = DECIDE;
            DECIDE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decision datapath
    logic            go_up, do_step, reversal, hit_max, hit_min;
    logic            dir_new;
    logic [XW-1:0]   step_eff, duty_x, duty_new_x;
    logic [DUTY_W-1:0] duty_new;

`ifdef MPPT_ADAPTIVE_STEP_EN
    logic [XW-1:0] step_q;
    logic [1:0]    streak_q;
`endif

    always_comb begin
        go_up    = dir_q;
        do_step  = 1'b1;
        reversal = 1'b0;
        if (!first_q) begin
            if (p_q < prev_power) begin
                go_up    = !dir_q;
                reversal = 1'b1;
            end else if (p_q == prev_power) begin
                do_step = 1'b0;
            end
        end
`ifdef MPPT_ADAPTIVE_STEP_EN
        step_eff = reversal ? STEP_X : step_q;
`else
        step_eff = STEP_X;
`endif
        duty_x     = XW'(duty_q);
        hit_max    = 1'b0;
        hit_min    = 1'b0;
        duty_new_x = duty_x;
        if (go_up) begin
            if (duty_x + step_eff >= MAX_X) begin
                duty_new_x = MAX_X;
                hit_max    = 1'b1;
            end else begin
                duty_new_x = duty_x + step_eff;
            end
        end else begin
            if (duty_x <= MIN_X + step_eff) begin
                duty_new_x = MIN_X;
                hit_min    = 1'b1;
            end else begin
                duty_new_x = duty_x - step_eff;
            end
        end
        dir_new = go_up;
        if (hit_max) dir_new = 1'b0;
        if (hit_min) dir_new = 1'b1;
        duty_new = DUTY_W'(duty_new_x);
        if (!do_step) begin
            duty_new = duty_q;
            dir_new  = dir_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            i_q        <= '0;
            p_q        <= '0;
            prev_power <= '0;
            power_q    <= '0;
            first_q    <= 1'b1;
            duty_q     <= DUTY_W'(DUTY_INIT);
            dir_q      <= 1'b1;
        end else begin
            if (handshake) begin
                v_q <= v_sample;
                i_q <= i_sample;
            end
            if (state == MULT)
                p_q <= PW'(v_q) * PW'(i_q);
            if (state == DECIDE) begin
                prev_power <= p_q;
                power_q    <= p_q;
                first_q    <= 1'b0;
                duty_q     <= duty_new;
                dir_q      <= dir_new;
            end
        end
    end

`ifdef MPPT_ADAPTIVE_STEP_EN
    // Step grows only on a run of same-direction moves; any hold, reversal or clamp restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= STEP_X;
            streak_q <= 2'd0;
        end else if (state == DECIDE) begin
            if (!do_step || hit_max || hit_min) begin
                step_q   <= STEP_X;
                streak_q <= 2'd0;
            end else if (reversal) begin
                step_q   <= STEP_X;
                streak_q <= 2'd1;
            end else if (streak_q != 2'd0) begin
                step_q   <= (step_q << 1) > (STEP_X << 2) ? (STEP_X << 2) : (step_q << 1);
                streak_q <= 2'd2;
            end else begin
                streak_q <= 2'd1;
            end
        end
    end
`endif

    assign duty   = duty_q;
    assign power  = power_q;
    assign dir_up = dir_q;

    // PWM: duty_active only changes at the wrap so a period never sees a mixed width.
    logic [DUTY_W-1:0] cnt, cnt_nxt, duty_active, da_nxt;

    always_comb begin
        cnt_nxt = cnt + DUTY_W'(1);
        da_nxt  = (cnt == '1) ? duty_q : duty_active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            duty_active  <= DUTY_W'(DUTY_INIT);
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            duty_active  <= da_nxt;
            pwm_out      <= (cnt_nxt < da_nxt);
            period_start <= (cnt == '1);
        end
    end

endmodule

// File: tb/tb_mppt_po_controller.sv
// Directed bench for mppt_po_controller (default build, fixed step).
module tb_mppt_po_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  v_sample, i_sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  duty;
    logic [15:0] power;
    logic        dir_up;
    logic        pwm_out;
    logic        period_start;

    int total = 0;
    int bad   = 0;

    mppt_po_controller dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .v_sample(v_sample), .i_sample(i_sample),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .duty(duty), .power(power), .dir_up(dir_up),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one sample and return at the first negedge where the result is visible.
    task automatic send(input logic [7:0] v, input logic [7:0] i);
        int k = 0;
        while (!sample_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready_timeout", 32'd0, 32'd1);
        v_sample     = v;
        i_sample     = i;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hi, ps, k;
        rst_n = 1'b0; enable = 1'b1; sample_valid = 1'b0;
        v_sample = '0; i_sample = '0;
        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 128);
        chk("rst_power", power, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ready", sample_ready, 0);
        chk("rst_pstart", period_start, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", sample_ready, 1);

        // First sample: latency check at N+2 then result at N+3
        v_sample = 8'd100; i_sample = 8'd50; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("busy_ready", sample_ready, 0);
        @(negedge clk);
        chk("latency_power", power, 0);
        @(negedge clk);
        chk("s1_power", power, 5000);
        chk("s1_duty", duty, 132);
        chk("s1_dir", dir_up, 1);
        chk("s1_ready", sample_ready, 1);

        send(8'd100, 8'd40);
        chk("s2_power", power, 4000);
        chk("s2_dir", dir_up, 0);
        chk("s2_duty", duty, 128);
        send(8'd80, 8'd50);
        chk("s3_duty_hold", duty, 128);
        chk("s3_dir_hold", dir_up, 0);

        // Enable low: valid is ignored while not ready
        enable = 1'b0;
        #1 chk("en_ready_drop", sample_ready, 0);
        v_sample = 8'd255; i_sample = 8'd255; sample_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("en_power_held", power, 4000);
        chk("en_duty_held", duty, 128);
        enable = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("en_resume_power", power, 65025);
        chk("en_resume_duty", duty, 124);
        chk("en_resume_dir", dir_up, 0);

        // Walk duty down to 64 with rising power (65025 -> drop first to re-base)
        send(8'd100, 8'd40);          // 4000 < 65025: reverse up -> 128
        chk("rebase_duty", duty, 128);
        send(8'd100, 8'd39);          // 3900 < 4000: reverse down -> 124
        chk("rebase_dir", dir_up, 0);
        for (int n = 0; n < 15; n++) send(8'd100, 8'(40 + n));
        chk("walk_duty", duty, 64);
        chk("walk_dir", dir_up, 0);

        // PWM: full period at 64, mid-period update must not alter this period
        k = 0;
        while (!period_start && k < 600) begin @(negedge clk); k++; end
        if (k >= 600) chk("pstart_timeout", 32'd0, 32'd1);
        hi = 0; ps = 0;
        for (int c = 0; c < 256; c++) begin
            if (c > 0) @(negedge clk);
            if (pwm_out) hi++;
            if (period_start) ps++;
            if (c == 10) begin
                v_sample = 8'd100; i_sample = 8'd55; sample_valid = 1'b1;
            end
            if (c == 11) sample_valid = 1'b0;
        end
        chk("pwm_hi_64", hi, 64);
        chk("pstart_once", ps, 1);
        chk("mid_duty", duty, 60);
        @(negedge clk);
        chk("pstart_256", period_start, 1);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            if (c > 0) @(negedge clk);
            if (pwm_out) hi++;
        end
        chk("pwm_hi_60", hi, 60);

        // Reset while a sample is in flight
        v_sample = 8'd200; i_sample = 8'd200; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("midrst_duty", duty, 128);
        chk("midrst_power", power, 0);
        chk("midrst_dir", dir_up, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_power_stays", power, 0);

        // Upper clamp
        send(8'd10, 8'd100);
        chk("clamp_start", duty, 132);
        for (int n = 1; n <= 26; n++) send(8'd10, 8'(100 + n));
        chk("clamp_236", duty, 236);
        chk("clamp_dir_up", dir_up, 1);
        send(8'd10, 8'd127);
        chk("clamp_240", duty, 240);
        chk("clamp_flip", dir_up, 0);
        send(8'd10, 8'd128);
        chk("clamp_away_236", duty, 236);
        chk("clamp_away_dir", dir_up, 0);
        send(8'd10, 8'd120);
        chk("clamp_resat_240", duty, 240);
        chk("clamp_resat_dir", dir_up, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
